// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // Moore control word produced by the main FSM for the current state.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~(c & ~z);
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return ~(~z & (n == v));
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controller_cond_logic.sv
// NZCV flag storage and condition qualification of PC/register/memory writes.
module cond_logic import controller_pkg::*; (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pcs_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex, cond_ex_dly_q;
  logic [1:0] flag_write;

  assign cond_ex    = cond_eval(cond_i, flags_q);
  assign flag_write = flag_w_i & {2{cond_ex}};

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_write[0]) flags_d[1:0] = alu_flags_i[1:0];
  end

  // Writeback happens a cycle after the condition is judged, so it uses the delayed copy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q       <= 4'b0000;
      cond_ex_dly_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      cond_ex_dly_q <= cond_ex;
    end
  end

  assign pc_write_o  = (pcs_i & cond_ex_dly_q) | next_pc_i;
  assign reg_write_o = reg_w_i & cond_ex_dly_q;
  assign mem_write_o = mem_w_i & cond_ex_dly_q;

endmodule

// File: rtl/controller.sv
// Multicycle ARM-subset control unit: Moore main FSM, ALU decoder and PC-source logic.
module controller import controller_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;
  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic [1:0] flag_w;
  logic       cmd_ok;
  logic       pcs;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      MEMADR: ctrl.alu_src_b = SRCB_IMM;
      MEMRD:  ctrl.adr_src = 1'b1;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      EXECUTER: ctrl.alu_op = 1'b1;
      EXECUTEI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB: ctrl.reg_w = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_ALUOUT;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURES;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Unrecognised data-processing commands fall back to ADD and never touch the flags.
  always_comb begin
    ALUControl = ALU_ADD;
    cmd_ok     = 1'b0;
    flag_w     = 2'b00;
    if (ctrl.alu_op) begin
      cmd_ok = 1'b1;
      case (funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: cmd_ok = 1'b0;
      endcase
      if (cmd_ok)
        flag_w = {funct[0], funct[0] & (ALUControl == ALU_ADD || ALUControl == ALU_SUB)};
    end
  end

  assign pcs       = ((rd == 4'b1111) & ctrl.reg_w) | ctrl.branch;
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ImmSrc    = op;
  assign RegSrc    = {op == OP_MEM, op == OP_BR};

  cond_logic u_cond (
    .clk_i       (clk),
    .reset_i     (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .pcs_i       (pcs),
    .next_pc_i   (ctrl.next_pc),
    .reg_w_i     (ctrl.reg_w),
    .mem_w_i     (ctrl.mem_w),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );

endmodule

// File: tb/tb_controller.sv
// Bench for controller: per-instruction cycle schedule model plus literal spot checks.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  always #5 clk = ~clk;

  controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm, aluc;
  } obs_t;

  obs_t       want;
  logic       want_vld = 1'b0;
  int         cur_k = 0;
  obs_t       samp [0:7];
  logic [3:0] m_nzcv = 4'b0000;
  int         n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s @%0t cyc=%0d: got %0h want %0h", nm, $time, cur_k, act, exp_v);
  endtask

  // Compare every checked cycle away from the rising edge.
  always @(negedge clk) begin
    if (want_vld) begin
      samp[cur_k] = '{PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                      RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
      chk("PCWrite",    {3'b0, PCWrite},    {3'b0, want.pcw});
      chk("MemWrite",   {3'b0, MemWrite},   {3'b0, want.memw});
      chk("RegWrite",   {3'b0, RegWrite},   {3'b0, want.regw});
      chk("IRWrite",    {3'b0, IRWrite},    {3'b0, want.irw});
      chk("AdrSrc",     {3'b0, AdrSrc},     {3'b0, want.adr});
      chk("RegSrc",     {2'b0, RegSrc},     {2'b0, want.regsrc});
      chk("ALUSrcA",    {2'b0, ALUSrcA},    {2'b0, want.srca});
      chk("ALUSrcB",    {2'b0, ALUSrcB},    {2'b0, want.srcb});
      chk("ResultSrc",  {2'b0, ResultSrc},  {2'b0, want.res});
      chk("ImmSrc",     {2'b0, ImmSrc},     {2'b0, want.imm});
      chk("ALUControl", {2'b0, ALUControl}, {2'b0, want.aluc});
    end
  end

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction

  function automatic logic holds(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v, r;
    {n, z, cy, v} = fl;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      default: r = !z && (n == v);
    endcase
    return r ^ c[0];
  endfunction

  // {known, alu code} for a data-processing command field
  function automatic logic [2:0] dp_cmd(input logic [3:0] cmd);
    if (cmd == 4'b0100) return 3'b100;
    if (cmd == 4'b0010) return 3'b101;
    if (cmd == 4'b0000) return 3'b110;
    if (cmd == 4'b1100) return 3'b111;
    return 3'b000;
  endfunction

  function automatic int inst_len(input logic [19:0] ins);
    if (ins[15:14] == 2'b00) return 4;
    if (ins[15:14] == 2'b01) return ins[8] ? 5 : 4;
    return 3;
  endfunction

  function automatic obs_t exp_at(input logic [19:0] ins, input int k, input logic pass);
    obs_t e = '0;
    logic [1:0] op = ins[15:14];
    logic [5:0] f = ins[13:8];
    logic pc_dst = (ins[3:0] == 4'hF);
    e.imm    = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    if (k < 2) begin
      e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
      if (k == 0) begin e.irw = 1'b1; e.pcw = 1'b1; end
    end else if (op == 2'b00) begin
      if (k == 2) begin
        e.srcb = f[5] ? 2'b01 : 2'b00;
        e.aluc = dp_cmd(f[4:1]) & 3'b011;
      end else begin
        e.regw = pass; e.pcw = pass && pc_dst;
      end
    end else if (op == 2'b01) begin
      if (k == 2) e.srcb = 2'b01;
      else if (k == 3) begin e.adr = 1'b1; e.memw = !f[0] && pass; end
      else begin e.res = 2'b01; e.regw = pass; e.pcw = pass && pc_dst; end
    end else if (op == 2'b10) begin
      e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; e.pcw = pass;
    end
    return e;
  endfunction

  // Runs an instruction from its FETCH cycle; stop_at < length leaves it unfinished.
  task automatic run(input logic [19:0] ins, input logic [3:0] af, input int stop_at);
    int   len = inst_len(ins);
    logic pass = holds(ins[19:16], m_nzcv);
    logic [2:0] cmd = dp_cmd(ins[12:9]);
    Instr = ins; ALUFlags = af;
    for (int k = 0; k < len && k < stop_at; k++) begin
      cur_k = k; want = exp_at(ins, k, pass); want_vld = 1'b1;
      @(posedge clk); #1;
    end
    want_vld = 1'b0;
    if (stop_at >= len && ins[15:14] == 2'b00 && ins[8] && pass && cmd[2]) begin
      m_nzcv[3:2] = af[3:2];
      if (!cmd[1]) m_nzcv[1:0] = af[1:0];
    end
  endtask

  localparam int FULL = 99;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_IRWrite", {3'b0, IRWrite}, 4'h1);
    chk("rst_PCWrite", {3'b0, PCWrite}, 4'h1);
    chk("rst_ALUSrcB", {2'b0, ALUSrcB}, 4'h2);

    run(mk(4'hE, 2'b00, 6'b000100, 4'h0), 4'b0000, FULL);            // SUB R0,R15,R15
    chk("sub_exec_aluc", {2'b0, samp[2].aluc}, 4'h1);
    chk("sub_wb_regw",   {3'b0, samp[3].regw}, 4'h1);
    run(mk(4'hE, 2'b00, 6'b101000, 4'h2), 4'b0000, FULL);            // ADD R2,R0,#5
    chk("addi_srcb", {2'b0, samp[2].srcb}, 4'h1);
    run(mk(4'hE, 2'b01, 6'b011001, 4'h2), 4'b0000, FULL);            // LDR
    chk("ldr_wb_res",  {2'b0, samp[4].res}, 4'h1);
    chk("ldr_wb_regw", {3'b0, samp[4].regw}, 4'h1);
    run(mk(4'hE, 2'b01, 6'b011000, 4'h2), 4'b0000, FULL);            // STR
    chk("str_memw",   {3'b0, samp[3].memw}, 4'h1);
    chk("str_regsrc", {2'b0, samp[3].regsrc}, 4'h2);
    run(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0100, FULL);            // BEQ, Z=0
    chk("beq_nt_pcw", {3'b0, samp[2].pcw}, 4'h0);
    run(mk(4'hE, 2'b00, 6'b000101, 4'h0), 4'b0100, FULL);            // SUBS -> Z=1
    run(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BEQ taken
    chk("beq_t_pcw", {3'b0, samp[2].pcw}, 4'h1);
    run(mk(4'hE, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // B
    chk("b_pcw", {3'b0, samp[2].pcw}, 4'h1);
    run(mk(4'hE, 2'b00, 6'b000000, 4'h3), 4'b0000, FULL);            // AND
    chk("and_aluc", {2'b0, samp[2].aluc}, 4'h2);
    run(mk(4'hE, 2'b00, 6'b011000, 4'h3), 4'b0000, FULL);            // ORR
    chk("orr_aluc", {2'b0, samp[2].aluc}, 4'h3);
    run(mk(4'hF, 2'b00, 6'b001000, 4'h2), 4'b0000, FULL);            // ADD with NV
    chk("nv_regw", {3'b0, samp[3].regw}, 4'h0);
    run(mk(4'hE, 2'b00, 6'b001001, 4'h1), 4'b0011, FULL);            // ADDS -> C,V set
    run(mk(4'h2, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BCS taken
    run(mk(4'hE, 2'b00, 6'b000001, 4'h1), 4'b1000, FULL);            // ANDS: NZ only
    run(mk(4'h4, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BMI taken
    run(mk(4'hB, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BLT: N==V, not taken
    chk("blt_pcw", {3'b0, samp[2].pcw}, 4'h0);
    run(mk(4'hE, 2'b00, 6'b011111, 4'h1), 4'b0100, FULL);            // unknown cmd with S
    run(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BEQ: Z untouched
    run(mk(4'hE, 2'b00, 6'b001000, 4'hF), 4'b0000, FULL);            // ADD R15
    chk("pc_dst_pcw", {3'b0, samp[3].pcw}, 4'h1);
    run(mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'b0000, FULL);            // undefined op
    run(mk(4'hE, 2'b00, 6'b000101, 4'h0), 4'b0100, FULL);            // SUBS -> Z=1
    run(mk(4'hE, 2'b00, 6'b001001, 4'h0), 4'b0100, 2);               // ADDS cut short
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_nzcv = 4'b0000;
    run(mk(4'h0, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BEQ after reset
    chk("rst_beq_pcw", {3'b0, samp[2].pcw}, 4'h0);
    run(mk(4'h1, 2'b10, 6'b000000, 4'h0), 4'b0000, FULL);            // BNE taken
    run(mk(4'hE, 2'b00, 6'b000100, 4'h0), 4'b0000, FULL);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
